// File: rtl/marmot_wb_sram_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : marmot_wb_sram_bridge_if
// Description : Wishbone slave-side bundle for the data-cache SRAM bridge.
//               The master modport is the management SoC (or a bench) and
//               the slave modport is the bridge.
// Revision    : 1.0 - initial release
// ============================================================================
interface marmot_wb_sram_bridge_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface
`default_nettype wire

// File: rtl/marmot_wb_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module      : marmot_wb_sram_bridge
// Description : Wishbone host port onto the 64-bit data-cache RW0 port.
//               The core always wins the port; the host issues only while
//               the core is held in reset or idle. 32-bit host transfers
//               map onto one half of a 64-bit RAM word.
//               Optional macro MARMOT_WB_SRAM_RMW_EN: partial-byte host
//               writes run read-modify-write; otherwise they are dropped,
//               acked, and flagged on err_o.
// Revision    : 1.0 - initial release
// ============================================================================
module marmot_wb_sram_bridge #(
    parameter int          ADDR_W    = 11,
    parameter logic [31:0] BASE_ADDR = 32'h3001_0000,
    parameter int          WIN_BITS  = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    marmot_wb_sram_bridge_if.slave wb,
    input  logic                  core_hold,
    input  logic                  core_en,
    input  logic                  core_wmode,
    input  logic [ADDR_W-1:0]     core_addr,
    input  logic [63:0]           core_wdata,
    input  logic [1:0]            core_wmask,
    output logic [63:0]           core_rdata,
    output logic                  ram_en,
    output logic                  ram_wmode,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [63:0]           ram_wdata,
    output logic [1:0]            ram_wmask,
    input  logic [63:0]           ram_rdata,
    output logic                  err_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_WAIT = 3'd1,
        S_RMW_RD  = 3'd2,
        S_RMW_WR  = 3'd3,
        S_ACK     = 3'd4
    } state_t;

    state_t              r_state;
    logic                r_ack;
    logic [31:0]         r_dat_o;
    logic                r_err;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_half;

    logic                w_req;
    logic                w_host_go;
    logic                w_full;
    logic                w_none;
    logic                w_start;
    logic [ADDR_W-1:0]   w_word;
    logic [31:0]         w_old_half;
    logic                w_h_en;
    logic                w_h_wmode;
    logic [ADDR_W-1:0]   w_h_addr;
    logic [63:0]         w_h_wdata;
    logic [1:0]          w_h_wmask;
    logic                w_unused_bits;

    assign w_req = wb.wbs_cyc_i & wb.wbs_stb_i &
                   (wb.wbs_adr_i[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]);
    assign w_host_go     = core_hold | ~core_en;
    assign w_full        = (wb.wbs_sel_i == 4'hF);
    assign w_none        = (wb.wbs_sel_i == 4'h0);
    assign w_word        = wb.wbs_adr_i[3 +: ADDR_W];
    // Request accepted only from IDLE, with the port free and out of reset
    assign w_start       = (r_state == S_IDLE) & w_req & w_host_go & rst_n;
    assign w_old_half    = r_half ? ram_rdata[63:32] : ram_rdata[31:0];
    assign w_unused_bits = &{1'b0, wb.wbs_adr_i[1:0]};

`ifdef MARMOT_WB_SRAM_RMW_EN
    logic [3:0]  r_sel;
    logic [31:0] r_dat;
    logic [31:0] r_merge;
    logic [31:0] w_merge;

    // Byte merge of the pending write data over the half just read back
    for (genvar b = 0; b < 4; b++) begin : g_merge
        assign w_merge[8*b +: 8] = r_sel[b] ? r_dat[8*b +: 8] : w_old_half[8*b +: 8];
    end
`endif

    // Host command presented to the RAM in the cycle it issues
    always_comb begin
        w_h_en    = 1'b0;
        w_h_wmode = 1'b0;
        w_h_addr  = w_word;
        w_h_wdata = {wb.wbs_dat_i, wb.wbs_dat_i};
        w_h_wmask = wb.wbs_adr_i[2] ? 2'b10 : 2'b01;
        if (w_start) begin
            if (!wb.wbs_we_i) begin
                w_h_en = 1'b1;
            end else if (w_full) begin
                w_h_en    = 1'b1;
                w_h_wmode = 1'b1;
            end
`ifdef MARMOT_WB_SRAM_RMW_EN
            else if (!w_none) begin
                w_h_en = 1'b1;
            end
`endif
        end
`ifdef MARMOT_WB_SRAM_RMW_EN
        if (r_state == S_RMW_WR && wb.wbs_cyc_i && w_host_go) begin
            w_h_en    = 1'b1;
            w_h_wmode = 1'b1;
            w_h_addr  = r_addr;
            w_h_wdata = {r_merge, r_merge};
            w_h_wmask = r_half ? 2'b10 : 2'b01;
        end
`endif
    end

    // Port arbitration: core commands pass through unless the host issues
    always_comb begin
        ram_en    = w_host_go ? w_h_en : core_en;
        ram_wmode = w_h_en ? w_h_wmode : core_wmode;
        ram_addr  = w_h_en ? w_h_addr  : core_addr;
        ram_wdata = w_h_en ? w_h_wdata : core_wdata;
        ram_wmask = w_h_en ? w_h_wmask : core_wmask;
    end

    assign core_rdata   = ram_rdata;
    assign wb.wbs_ack_o = r_ack;
    assign wb.wbs_dat_o = r_dat_o;
    assign err_o        = r_err;

    // Transfer sequencing with registered ack, read data and error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ack   <= 1'b0;
            r_dat_o <= 32'h0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_half  <= 1'b0;
`ifdef MARMOT_WB_SRAM_RMW_EN
            r_sel   <= 4'h0;
            r_dat   <= 32'h0;
            r_merge <= 32'h0;
`endif
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_addr <= w_word;
                        r_half <= wb.wbs_adr_i[2];
`ifdef MARMOT_WB_SRAM_RMW_EN
                        r_sel  <= wb.wbs_sel_i;
                        r_dat  <= wb.wbs_dat_i;
`endif
                        if (!wb.wbs_we_i) begin
                            r_state <= S_RD_WAIT;
                        end else if (w_full || w_none) begin
                            r_state <= S_ACK;
                            r_ack   <= 1'b1;
                        end else begin
`ifdef MARMOT_WB_SRAM_RMW_EN
                            r_state <= S_RMW_RD;
`else
                            r_state <= S_ACK;
                            r_ack   <= 1'b1;
                            r_err   <= 1'b1;
`endif
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (!wb.wbs_cyc_i) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_dat_o <= w_old_half;
                        r_state <= S_ACK;
                        r_ack   <= 1'b1;
                    end
                end
`ifdef MARMOT_WB_SRAM_RMW_EN
                S_RMW_RD: begin
                    if (!wb.wbs_cyc_i) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_merge <= w_merge;
                        r_state <= S_RMW_WR;
                    end
                end
                S_RMW_WR: begin
                    if (!wb.wbs_cyc_i) begin
                        r_state <= S_IDLE;
                    end else if (w_host_go) begin
                        r_state <= S_ACK;
                        r_ack   <= 1'b1;
                    end
                end
`endif
                S_ACK: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
